// File: rtl/round_controller_if.sv
// Handshake bundle between the round controller, the player inputs, the
// random generator and the display logic.
interface round_controller_if;
  logic       start;
  logic       submit;
  logic [7:0] answer;
  logic [7:0] rnd_value;
  logic       rnd_trigger;
  logic [7:0] target;
  logic [7:0] score;
  logic [7:0] round_idx;
  logic       playing;
  logic       correct;
  logic       wrong;
  logic       game_over;

  modport master (
    output start, submit, answer, rnd_value,
    input  rnd_trigger, target, score, round_idx,
    input  playing, correct, wrong, game_over
  );

  modport slave (
    input  start, submit, answer, rnd_value,
    output rnd_trigger, target, score, round_idx,
    output playing, correct, wrong, game_over
  );
endinterface

// File: rtl/round_controller.sv
// Binary-counting game sequencer: fetches a target per round, judges the
// player's answer, keeps score and round count, and enforces a round timeout.
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// ARM    | one-cycle request to the random generator
// LOAD   | capture rnd_value as the new target, clear the round timer
// PLAY   | waiting for submit or timeout
// RESULT | one-cycle correct/wrong pulse, advance or finish
// DONE   | game over, results held until the next start
module round_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ROUNDS     = 10
) (
  input logic         clk,
  input logic         rst,
  round_controller_if.slave bus
);
  localparam int            TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ROUND_LAST = 8'(MAX_ROUNDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          win_q, win_d;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    round_d  = round_q;
    timer_d  = timer_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_ARM;
          score_d = 8'd0;
          round_d = 8'd0;
          timer_d = '0;
        end
      end
      S_ARM: state_d = S_LOAD;
      S_LOAD: begin
        target_d = bus.rnd_value;
        timer_d  = '0;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        // Timer parks on its last value so it can never wrap.
        if (timer_q != TIMER_LAST) timer_d = timer_q + 1'b1;
        if (bus.submit) begin
          win_d   = (bus.answer == target_q);
          if (bus.answer == target_q) score_d = score_q + 8'd1;
          state_d = S_RESULT;
        end else if (timer_q == TIMER_LAST) begin
          win_d   = 1'b0;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (round_q == ROUND_LAST) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 8'd1;
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= 8'd0;
      score_q  <= 8'd0;
      round_q  <= 8'd0;
      timer_q  <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      score_q  <= score_d;
      round_q  <= round_d;
      timer_q  <= timer_d;
      win_q    <= win_d;
    end
  end

  assign bus.rnd_trigger = (state_q == S_ARM);
  assign bus.playing     = (state_q == S_ARM) || (state_q == S_LOAD) ||
                           (state_q == S_PLAY) || (state_q == S_RESULT);
  assign bus.correct     = (state_q == S_RESULT) && win_q;
  assign bus.wrong       = (state_q == S_RESULT) && !win_q;
  assign bus.game_over   = (state_q == S_DONE);
  assign bus.target      = target_q;
  assign bus.score       = score_q;
  assign bus.round_idx   = round_q;
endmodule
